// File: rtl/dmem_pkg.sv
// ============================================================================
// Package  : dmem_pkg
// Purpose  : Shared arbiter state encoding and load/store size codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_D_OUT = 2'd1,
    ST_I_OUT = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Byte enables, store-lane replication and misalignment detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_ofs,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_ofs;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_be       = 4'b0011 << i_ofs;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_ofs[0];
      end
      // size code 3 behaves as a word access
      default: begin
        o_be       = 4'b1111;
        o_misalign = |i_ofs;
      end
    endcase
    if (!i_we) begin
      o_be = 4'b0000;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares one single-port data RAM between the load/store (D) and
//            fetch (I) paths, with D priority and bounded I starvation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_done,
  output logic          d_misalign,
  output logic          d_stall,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_done,
  output logic          i_stall,
  output logic          ram_cs,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  state_t      r_state;
  logic [3:0]  r_starve;
  logic        r_d_done;
  logic        r_d_mis;
  logic        r_d_cap;
  logic        r_i_done;
  logic        r_i_cap;
  logic [31:0] r_d_rdata;
  logic [31:0] r_i_rdata;

  logic        w_d_elig;
  logic        w_i_elig;
  logic        w_grant_d;
  logic        w_grant_i;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic        w_unused;

  dmem_lane_align u_align (
    .i_we       (d_we),
    .i_size     (d_size),
    .i_ofs      (d_addr[1:0]),
    .i_wdata    (d_wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign)
  );

  // The requester that owns the outstanding access is still holding its
  // (already served) request this cycle, so it may not issue again.
  assign w_d_elig  = d_req & (r_state != ST_D_OUT);
  assign w_i_elig  = i_req & (r_state != ST_I_OUT);
  assign w_grant_i = w_i_elig & (~w_d_elig | (r_starve == c_STARVE_MAX));
  assign w_grant_d = w_d_elig & ~w_grant_i;

  always_comb begin
    ram_cs    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst) begin
      if (w_grant_d && !w_misalign) begin
        ram_cs    = 1'b1;
        ram_be    = w_be;
        ram_addr  = d_addr[AW+1:2];
        ram_wdata = w_wdata;
      end else if (w_grant_i) begin
        ram_cs   = 1'b1;
        ram_addr = i_addr[AW+1:2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_starve  <= 4'd0;
      r_d_done  <= 1'b0;
      r_d_mis   <= 1'b0;
      r_d_cap   <= 1'b0;
      r_i_done  <= 1'b0;
      r_i_cap   <= 1'b0;
      r_d_rdata <= 32'd0;
      r_i_rdata <= 32'd0;
    end else begin
      if (w_grant_d) begin
        r_state <= ST_D_OUT;
      end else if (w_grant_i) begin
        r_state <= ST_I_OUT;
      end else begin
        r_state <= ST_IDLE;
      end

      r_d_done <= w_grant_d;
      r_d_mis  <= w_grant_d & w_misalign;
      r_d_cap  <= w_grant_d & ~w_misalign & ~d_we;
      r_i_done <= w_grant_i;
      r_i_cap  <= w_grant_i;

      if (r_d_cap) begin
        r_d_rdata <= ram_rdata;
      end
      if (r_i_cap) begin
        r_i_rdata <= ram_rdata;
      end

      if (!i_req || w_grant_i) begin
        r_starve <= 4'd0;
      end else if (w_grant_d && (r_starve != c_STARVE_MAX)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

  // Read data is forwarded in the completion cycle, then held by the register.
  assign d_rdata    = r_d_cap ? ram_rdata : r_d_rdata;
  assign i_rdata    = r_i_cap ? ram_rdata : r_i_rdata;
  assign d_done     = r_d_done;
  assign d_misalign = r_d_mis;
  assign i_done     = r_i_done;
  assign d_stall    = d_req & ~r_d_done;
  assign i_stall    = i_req & ~r_i_done;

  assign w_unused = &{1'b0, d_addr[31:AW+2], i_addr[31:AW+2], i_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Purpose  : Scoreboard bench for dmem_port_arbiter with a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  localparam int AW   = 10;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          d_req, d_we, d_done, d_misalign, d_stall;
  logic [1:0]    d_size;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          i_req, i_done, i_stall;
  logic [31:0]   i_addr, i_rdata;
  logic          ram_cs;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_misalign(d_misalign), .d_stall(d_stall),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .ram_cs(ram_cs), .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Environment RAM: synchronous single-port, read data valid the next cycle.
  logic [31:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_be == 4'b0000) begin
        ram_rdata <= env_mem[ram_addr];
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (ram_be[k]) env_mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory plus owner / starvation bookkeeping.
  logic [7:0] ref_b [0:4095];

  typedef struct {
    int          due;
    logic        mis;
    logic        load;
    logic [31:0] data;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  int   m_owner  = 0;
  int   m_starve = 0;
  logic [31:0] m_drd = 32'd0;
  logic [31:0] m_ird = 32'd0;

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int b;
    b = {20'd0, addr[11:2], 2'b00};
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  always @(negedge clk) begin
    int          win, a, n, base;
    logic        d_el, i_el;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    exp_t        e;
    if (rst) begin
      m_owner  = 0;
      m_starve = 0;
      chk("rst_ram_cs", ram_cs, 0);
      chk("rst_ram_be", ram_be, 0);
      chk("rst_d_done", d_done, 0);
      chk("rst_i_done", i_done, 0);
    end else begin
      chk("d_stall", d_stall, d_req & ~d_done);
      chk("i_stall", i_stall, i_req & ~i_done);
      d_el = d_req && (m_owner != 1);
      i_el = i_req && (m_owner != 2);
      win = 0;
      if (d_el && i_el) win = (m_starve == SMAX) ? 2 : 1;
      else if (d_el)    win = 1;
      else if (i_el)    win = 2;

      if (win == 1) begin
        a = int'(d_addr[1:0]);
        n = (d_size == 2'd0) ? 1 : (d_size == 2'd1) ? 2 : 4;
        e.due  = cyc + 1;
        e.load = 1'b0;
        e.data = 32'd0;
        e.mis  = ((a % n) != 0);
        if (e.mis) begin
          chk("mis_ram_cs", ram_cs, 0);
        end else begin
          chk("d_ram_cs", ram_cs, 1);
          chk("d_ram_addr", 32'(ram_addr), {22'd0, d_addr[11:2]});
          if (d_we) begin
            ebe = 4'b0000;
            for (int k = 0; k < 4; k++) if (k >= a && k < a + n) ebe[k] = 1'b1;
            ewd = (n == 1) ? {4{d_wdata[7:0]}} : (n == 2) ? {2{d_wdata[15:0]}} : d_wdata;
            chk("st_ram_be", ram_be, ebe);
            chk("st_ram_wdata", ram_wdata, ewd);
            base = {20'd0, d_addr[11:2], 2'b00};
            for (int k = 0; k < n; k++) ref_b[base + a + k] = d_wdata[8*k +: 8];
          end else begin
            chk("ld_ram_be", ram_be, 0);
            e.load = 1'b1;
            e.data = ref_word(d_addr);
          end
        end
        dq.push_back(e);
        m_starve = i_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
      end else if (win == 2) begin
        chk("i_ram_cs", ram_cs, 1);
        chk("i_ram_be", ram_be, 0);
        chk("i_ram_addr", 32'(ram_addr), {22'd0, i_addr[11:2]});
        e.due  = cyc + 1;
        e.mis  = 1'b0;
        e.load = 1'b1;
        e.data = ref_word(i_addr);
        iq.push_back(e);
        m_starve = 0;
      end else begin
        chk("idle_ram_cs", ram_cs, 0);
        if (!i_req) m_starve = 0;
      end
      m_owner = win;
    end
  end

  // Monitor: pops expectations when the DUT signals completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      dq.delete();
      iq.delete();
      m_drd = 32'd0;
      m_ird = 32'd0;
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_misalign", d_misalign, 0);
    end else begin
      if (d_done) begin
        if (dq.size() == 0 || dq[0].due > cyc) begin
          chk("d_done_unexpected", d_done, 0);
        end else begin
          e = dq.pop_front();
          chk("d_misalign", d_misalign, e.mis);
          if (e.load) m_drd = e.data;
        end
      end else begin
        chk("d_misalign_idle", d_misalign, 0);
        if (dq.size() != 0 && dq[0].due <= cyc) begin
          chk("d_done_missing", d_done, 1);
          void'(dq.pop_front());
        end
      end
      chk("d_rdata", d_rdata, m_drd);

      if (i_done) begin
        if (iq.size() == 0 || iq[0].due > cyc) begin
          chk("i_done_unexpected", i_done, 0);
        end else begin
          e = iq.pop_front();
          m_ird = e.data;
        end
      end else if (iq.size() != 0 && iq[0].due <= cyc) begin
        chk("i_done_missing", i_done, 1);
        void'(iq.pop_front());
      end
      chk("i_rdata", i_rdata, m_ird);
    end
  end

  task automatic d_access(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd);
    int t;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = addr; d_wdata = wd;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!d_done && t < 50);
    chk("d_access_done", d_done, 1);
  endtask

  task automatic d_idle();
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic i_access(input logic [31:0] addr);
    int t;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = addr;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!i_done && t < 50);
    chk("i_access_done", i_done, 1);
  endtask

  task automatic i_idle();
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_addr = 32'd0; d_wdata = 32'd0;
    i_req = 1'b0; i_addr = 32'd0;
    for (int k = 0; k < 4096; k++) ref_b[k] = 8'd0;
    for (int k = 0; k < (1 << AW); k++) env_mem[k] = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Word store then load of the same location.
    d_access(1'b1, 2'd2, 32'h40, 32'hDEADBEEF);
    d_access(1'b0, 2'd2, 32'h40, 32'd0);
    d_idle();
    chk("lw_deadbeef", d_rdata, 32'hDEADBEEF);

    // Byte and half lanes merged into the same word.
    d_access(1'b1, 2'd0, 32'h43, 32'h000000A5);
    d_access(1'b1, 2'd1, 32'h42, 32'h00001234);
    d_access(1'b0, 2'd2, 32'h40, 32'd0);
    d_idle();
    chk("lane_merge", d_rdata, 32'h1234BEEF);

    // Misaligned accesses leave the RAM and d_rdata alone.
    d_access(1'b1, 2'd1, 32'h41, 32'h0000FFFF);
    d_access(1'b0, 2'd2, 32'h42, 32'd0);
    d_idle();
    chk("mis_hold", d_rdata, 32'h1234BEEF);

    // Reset while a load is outstanding.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h40;
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_d_rdata", d_rdata, 0);
    chk("rst_mid_d_done", d_done, 0);
    @(posedge clk); #1 rst = 1'b0;
    d_access(1'b0, 2'd2, 32'h40, 32'd0);
    d_idle();
    chk("post_rst_load", d_rdata, 32'h1234BEEF);

    // Contention: both paths requesting continuously.
    fork
      begin
        for (int j = 0; j < 10; j++) d_access(1'b0, 2'd2, 32'h40 + 32'(4 * j), 32'd0);
        d_idle();
      end
      begin
        for (int j = 0; j < 10; j++) i_access(32'h80 + 32'(4 * j));
        i_idle();
      end
    join

    // Randomized mix on both ports.
    fork
      begin
        for (int j = 0; j < 300; j++) begin
          d_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   {12'($urandom), 8'd0, 6'($urandom_range(16, 31)), 2'($urandom_range(0, 3)), 4'd0} >> 4,
                   $urandom);
          if ($urandom_range(0, 2) == 0) begin
            d_idle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
          end
        end
        d_idle();
      end
      begin
        for (int j = 0; j < 300; j++) begin
          i_access({$urandom_range(0, 1023), 2'($urandom_range(0, 3))} & 32'hFFFF_F0FF | 32'h40);
          if ($urandom_range(0, 2) == 0) begin
            i_idle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
          end
        end
        i_idle();
      end
    join

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
